instr_fetch_unit: RTL and testbench

Fetch stage on the requesting side of the 16-bit instruction memory port. Holds the program counter, drives the byte address to the combinational instruction memory, and captures each returned 16-bit word with its PC into a small FIFO. Decode consumes that FIFO through a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and reload the PC.

---
 rtl/isa_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 88 ++++++++
 tb/tb_instr_fetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit core.
// Provides address/instruction widths, the PC increment, the 4-bit major
// opcode constants and the fetch FIFO entry type {pc, instr}.
package isa_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    // Instruction memory is word-indexed by addr[15:1], so the PC steps by 2 bytes.
    localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

    localparam logic [3:0] OP_ADD  = 4'h0;  // ADD / ADC
    localparam logic [3:0] OP_NDU  = 4'h2;  // NDU / NDZ
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (clears storage too)
//   push         - write push_data at the tail
//   pop          - retire the head entry
//   flush        - discard all entries; has priority over push and pop
//   push_data    - entry to write
//   count        - number of valid entries, 0..DEPTH
//   head         - entry at the head (stale when count == 0)
module fetch_fifo
    import isa_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_data,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller misbehaves; a push
    // into a full FIFO is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != FULL_CNT) || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            // Leave storage untouched so the head outputs keep stale contents.
            rd_ptr <= wr_ptr;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage.
// Holds the PC, addresses the combinational instruction memory and queues
// each returned word with its PC for decode. Redirects flush the queue and
// reload the PC.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   fetch_en                - allow fetching; PC holds when low
//   imem_addr / imem_instr  - instruction memory byte address and returned word
//   redirect_valid/_pc      - taken branch/jump and its byte target
//   out_valid/_ready        - decode handshake for the FIFO head
//   out_instr / out_pc      - head instruction and its PC
//   misalign_err            - one-cycle pulse after a redirect to an odd target
module instr_fetch_unit
    import isa_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               misalign_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_INIT  = {RESET_PC[ADDR_W-1:1], 1'b0};

    logic [ADDR_W-1:0] pc;
    logic              misalign_q;
    logic [CNT_W-1:0]  count;
    logic              fetch;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // A full FIFO can still accept a word when the head leaves this cycle,
    // which is what sustains one instruction per cycle.
    always_comb begin
        pop              = out_valid && out_ready && !redirect_valid;
        fetch            = fetch_en && !redirect_valid &&
                           ((count != FULL_CNT) || (out_valid && out_ready));
        push_entry.pc    = pc;
        push_entry.instr = imem_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= PC_INIT;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && redirect_pc[0];
            if (redirect_valid) begin
                pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
            end else if (fetch) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fetch),
        .pop      (pop),
        .flush    (redirect_valid),
        .push_data(push_entry),
        .count    (count),
        .head     (head)
    );

    assign imem_addr    = pc;
    assign out_valid    = (count != '0);
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of per-cycle vectors for the
// main stream/backpressure/redirect flow, plus hand-written sequences for
// reset behaviour and PC wrap (second instance with RESET_PC = FFFE).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n, w_rst_n;
    logic        fe, rdy, rv;
    logic [15:0] rpc;
    logic        w_fe, w_rdy;

    logic [15:0] imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid, misalign_err;
    logic [15:0] w_imem_addr, w_imem_instr, w_out_instr, w_out_pc;
    logic        w_out_valid, w_misalign_err;

    int vectors;
    int miscompares;

    localparam logic [49:0] M_ALL  = '1;
    localparam logic [49:0] M_CTRL = {2'b11, 16'hFFFF, 32'h0};

    // Program image; unlisted words read as addr ^ 5A5A so every word differs.
    function automatic logic [15:0] mem_model(input logic [15:0] a);
        case (a)
            16'h0000: return 16'hF24A;
            16'h0002: return 16'hF494;
            16'h0004: return 16'hF6DE;
            16'h0006: return 16'hF928;
            16'h0010: return 16'h2561;
            16'h001E: return 16'hD010;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    assign imem_instr   = mem_model(imem_addr);
    assign w_imem_instr = mem_model(w_imem_addr);

    instr_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fe), .imem_addr(imem_addr),
        .imem_instr(imem_instr), .redirect_valid(rv), .redirect_pc(rpc),
        .out_valid(out_valid), .out_ready(rdy), .out_instr(out_instr),
        .out_pc(out_pc), .misalign_err(misalign_err)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE), .DEPTH(2)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .fetch_en(w_fe), .imem_addr(w_imem_addr),
        .imem_instr(w_imem_instr), .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .out_valid(w_out_valid), .out_ready(w_rdy), .out_instr(w_out_instr),
        .out_pc(w_out_pc), .misalign_err(w_misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [49:0] obs();
        return {out_valid, misalign_err, imem_addr, out_pc, out_instr};
    endfunction

    function automatic logic [49:0] obs_w();
        return {w_out_valid, w_misalign_err, w_imem_addr, w_out_pc, w_out_instr};
    endfunction

    task automatic check(input string name, input logic [49:0] got,
                         input logic [49:0] exp, input logic [49:0] mask);
        vectors++;
        if ((got & mask) !== (exp & mask)) begin
            miscompares++;
            $display("FAIL %s: got ov=%b mis=%b addr=%h pc=%h instr=%h, want ov=%b mis=%b addr=%h pc=%h instr=%h",
                     name, got[49], got[48], got[47:32], got[31:16], got[15:0],
                     exp[49], exp[48], exp[47:32], exp[31:16], exp[15:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        fe, rdy, rv;
        logic [15:0] rpc;
        logic        ov, mis;
        logic [15:0] addr, opc, oin;
        logic        dchk;
    } vec_t;

    vec_t tv [20];

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; w_rst_n = 1'b0;
        fe = 0; rdy = 0; rv = 0; rpc = '0; w_fe = 0; w_rdy = 0;

        //        fe rdy rv rpc       ov mis addr      pc        instr     dchk
        tv[0]  = '{1, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1};
        tv[1]  = '{1, 1, 0, 16'h0000, 1, 0, 16'h0002, 16'h0000, 16'hF24A, 1};
        tv[2]  = '{1, 1, 0, 16'h0000, 1, 0, 16'h0004, 16'h0002, 16'hF494, 1};
        tv[3]  = '{1, 1, 0, 16'h0000, 1, 0, 16'h0006, 16'h0004, 16'hF6DE, 1};
        tv[4]  = '{1, 0, 0, 16'h0000, 1, 0, 16'h0008, 16'h0006, 16'hF928, 1};
        tv[5]  = '{1, 0, 0, 16'h0000, 1, 0, 16'h000A, 16'h0006, 16'hF928, 1};
        tv[6]  = '{1, 1, 1, 16'h001E, 1, 0, 16'h000A, 16'h0006, 16'hF928, 1};
        tv[7]  = '{1, 1, 0, 16'h0000, 0, 0, 16'h001E, 16'h0000, 16'h0000, 0};
        tv[8]  = '{1, 1, 1, 16'h0011, 1, 0, 16'h0020, 16'h001E, 16'hD010, 1};
        tv[9]  = '{1, 1, 0, 16'h0000, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0};
        tv[10] = '{0, 1, 0, 16'h0000, 1, 0, 16'h0012, 16'h0010, 16'h2561, 1};
        tv[11] = '{0, 0, 1, 16'h0004, 0, 0, 16'h0012, 16'h0000, 16'h0000, 0};
        tv[12] = '{1, 0, 0, 16'h0000, 0, 0, 16'h0004, 16'h0000, 16'h0000, 0};
        tv[13] = '{1, 0, 0, 16'h0000, 1, 0, 16'h0006, 16'h0004, 16'hF6DE, 1};
        tv[14] = '{1, 0, 0, 16'h0000, 1, 0, 16'h0008, 16'h0004, 16'hF6DE, 1};
        tv[15] = '{1, 1, 0, 16'h0000, 1, 0, 16'h0008, 16'h0004, 16'hF6DE, 1};
        tv[16] = '{1, 1, 0, 16'h0000, 1, 0, 16'h000A, 16'h0006, 16'hF928, 1};
        tv[17] = '{0, 1, 0, 16'h0000, 1, 0, 16'h000C, 16'h0008, 16'h5A52, 1};
        tv[18] = '{0, 1, 0, 16'h0000, 1, 0, 16'h000C, 16'h000A, 16'h5A50, 1};
        tv[19] = '{0, 0, 0, 16'h0000, 0, 0, 16'h000C, 16'h0000, 16'h0000, 0};

        repeat (2) @(negedge clk);
        check("reset_state", obs(), 50'h0, M_ALL);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            fe = tv[i].fe; rdy = tv[i].rdy; rv = tv[i].rv; rpc = tv[i].rpc;
            #1;
            check($sformatf("vec%0d", i), obs(),
                  {tv[i].ov, tv[i].mis, tv[i].addr, tv[i].opc, tv[i].oin},
                  tv[i].dchk ? M_ALL : M_CTRL);
            step();
        end
        rv = 0;

        // Backpressure from reset: two words queued, address parks at 0004.
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; fe = 1; rdy = 0;
        step(); step();
        check("bp_full", obs(), {2'b10, 16'h0004, 16'h0000, 16'hF24A}, M_ALL);
        repeat (3) step();
        check("bp_hold", obs(), {2'b10, 16'h0004, 16'h0000, 16'hF24A}, M_ALL);
        rdy = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_drain%0d", k), obs(),
                  {2'b10, 16'h0004 + 16'(2 * k), 16'(2 * k), mem_model(16'(2 * k))}, M_ALL);
            step();
        end
        rdy = 0;

        // Asynchronous reset between edges with two entries queued.
        #2 rst_n = 1'b0;
        #1 check("async_rst", obs(), 50'h0, M_ALL);
        @(negedge clk);
        rst_n = 1'b1; rdy = 1;
        #1 check("restart0", obs(), 50'h0, M_CTRL);
        step();
        check("restart1", obs(), {2'b10, 16'h0002, 16'h0000, 16'hF24A}, M_ALL);
        step();
        check("restart2", obs(), {2'b10, 16'h0004, 16'h0002, 16'hF494}, M_ALL);

        // Misalign pulse cleared immediately by reset.
        rv = 1; rpc = 16'h0013;
        @(posedge clk);
        #1 rv = 0;
        check("mis_pulse", obs(), {2'b01, 16'h0012, 32'h0}, M_CTRL);
        #2 rst_n = 1'b0;
        #1 check("mis_rst", obs(), 50'h0, M_ALL);
        @(negedge clk);

        // PC wrap on the FFFE instance.
        w_fe = 1; w_rdy = 1; w_rst_n = 1'b1;
        #1 check("wrap0", obs_w(), {2'b00, 16'hFFFE, 32'h0}, M_ALL);
        step();
        check("wrap1", obs_w(), {2'b10, 16'h0000, 16'hFFFE, 16'hA5A4}, M_ALL);
        step();
        check("wrap2", obs_w(), {2'b10, 16'h0002, 16'h0000, 16'hF24A}, M_ALL);
        step();
        check("wrap3", obs_w(), {2'b10, 16'h0004, 16'h0002, 16'hF494}, M_ALL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
